mem_port_arbiter: RTL and testbench

- Shares the single-ported core memory bus between instruction fetch (IF) and the load/store unit (LS).
- Consumes the decoder's `memWR`/`memCtrl` encoding directly; sits between the pipeline and the memory model.
- Arbitrates between the two requesters, then sequences one bus transaction at a time with a ready handshake.
- LS side only: generates byte lanes, replicates store data, and sign/zero-extends load data.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters (IF, LS), the arbiter and the memory model.
// The arbiter connects through the slave modport; the pipeline/memory side uses master.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_ctrl;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_valid;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_valid, if_rdata, if_err,
        input  ls_req, ls_we, ls_ctrl, ls_addr, ls_wdata,
        output ls_gnt, ls_valid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_valid, if_rdata, if_err,
        output ls_req, ls_we, ls_ctrl, ls_addr, ls_wdata,
        input  ls_gnt, ls_valid, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, one transaction at a time.
// Optional bus-wait watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          owner_ls;
    logic [2:0]    ctrl_p1;
    logic [1:0]    off_p1;
    logic          if_win;
    logic          ls_win;
    logic          ls_legal;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] wait_cnt;
    logic          if_err_r;
`endif

    function automatic logic ls_ok(input logic we, input logic [2:0] ctrl, input logic [1:0] off);
        logic op_ok;
        logic align_ok;
        op_ok = we ? (ctrl >= 3'b101) : (ctrl <= 3'b100);
        case (ctrl)
            3'b001, 3'b100, 3'b110: align_ok = ~off[0];
            3'b010, 3'b111:         align_ok = (off == 2'b00);
            default:                align_ok = 1'b1;
        endcase
        return op_ok && align_ok;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl)
            3'b000, 3'b011, 3'b101: return 4'b0001 << off;
            3'b001, 3'b100, 3'b110: return off[1] ? 4'b1100 : 4'b0011;
            default:                return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] ctrl, input logic [31:0] w);
        case (ctrl)
            3'b101:  return {4{w[7:0]}};
            3'b110:  return {2{w[15:0]}};
            3'b111:  return w;
            default: return 32'h0;
        endcase
    endfunction

    // Shift the addressed lane down, then extend according to the load flavour.
    function automatic logic [31:0] load_ext(input logic [2:0] ctrl, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (ctrl)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return word;
            3'b011:  return {24'h0, b};
            3'b100:  return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    // Grants are only ever combinational from IDLE; reset masks them so every output is quiet.
    always_comb begin
        if_win = 1'b0;
        ls_win = 1'b0;
        if (state == IDLE && !rst) begin
            if (bus.ls_req && !(bus.if_req && starve_cnt == CW'(STARVE_MAX)))
                ls_win = 1'b1;
            else if (bus.if_req)
                if_win = 1'b1;
        end
    end

    assign bus.if_gnt = if_win;
    assign bus.ls_gnt = ls_win;
    assign ls_legal   = ls_ok(bus.ls_we, bus.ls_ctrl, bus.ls_addr[1:0]);

`ifdef MEM_TIMEOUT_EN
    assign bus.if_err = if_err_r;
`else
    assign bus.if_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            owner_ls      <= 1'b0;
            ctrl_p1       <= 3'b000;
            off_p1        <= 2'b00;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'h0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.if_valid  <= 1'b0;
            bus.if_rdata  <= 32'h0;
            bus.ls_valid  <= 1'b0;
            bus.ls_err    <= 1'b0;
            bus.ls_rdata  <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt      <= '0;
            if_err_r      <= 1'b0;
`endif
        end else begin
            bus.if_valid <= 1'b0;
            bus.if_rdata <= 32'h0;
            bus.ls_valid <= 1'b0;
            bus.ls_err   <= 1'b0;
            bus.ls_rdata <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            if_err_r     <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef MEM_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (if_win) begin
                        starve_cnt    <= '0;
                        owner_ls      <= 1'b0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_be    <= 4'b1111;
                        bus.mem_addr  <= {bus.if_addr[31:2], 2'b00};
                        bus.mem_wdata <= 32'h0;
                        state         <= BUSY;
                    end else if (ls_win) begin
                        if (bus.if_req)
                            starve_cnt <= starve_cnt + 1'b1;
                        owner_ls <= 1'b1;
                        ctrl_p1  <= bus.ls_ctrl;
                        off_p1   <= bus.ls_addr[1:0];
                        if (ls_legal) begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.ls_we;
                            bus.mem_be    <= lane_be(bus.ls_ctrl, bus.ls_addr[1:0]);
                            bus.mem_addr  <= {bus.ls_addr[31:2], 2'b00};
                            bus.mem_wdata <= store_data(bus.ls_ctrl, bus.ls_wdata);
                            state         <= BUSY;
                        end else begin
                            // Rejected request: no bus cycle, the error pulse lands in ERR.
                            bus.ls_valid <= 1'b1;
                            bus.ls_err   <= 1'b1;
                            state        <= ERR;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                        if (owner_ls) begin
                            bus.ls_valid <= 1'b1;
                            bus.ls_rdata <= load_ext(ctrl_p1, off_p1, bus.mem_rdata);
                        end else begin
                            bus.if_valid <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                        if (owner_ls) begin
                            bus.ls_valid <= 1'b1;
                            bus.ls_err   <= 1'b1;
                        end else begin
                            bus.if_valid <= 1'b1;
                            if_err_r     <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference of the access rules.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference rules ----------------
    function automatic int ref_size(input logic [2:0] c);
        case (c)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic bit ref_legal(input logic we, input logic [2:0] c, input logic [31:0] a);
        int off = int'(a[1:0]);
        bit is_store = (c >= 3'd5);
        return (we == is_store) && ((off % ref_size(c)) == 0);
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] c, input logic [31:0] a);
        logic [3:0] be = 4'h0;
        int off = int'(a[1:0]);
        int sz  = ref_size(c);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + sz) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] c, input logic [31:0] wd);
        logic [31:0] w;
        int sz = ref_size(c);
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = wd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] rd);
        longint v;
        int sz = ref_size(c);
        int off = int'(a[1:0]);
        v = (longint'(rd) >> (8 * off)) & ((64'sd1 <<< (8 * sz)) - 1);
        if ((c == 3'd0 || c == 3'd1) && v >= (64'sd1 <<< (8 * sz - 1)))
            v = v - (64'sd1 <<< (8 * sz));
        return v[31:0];
    endfunction

    // ---------------- transaction drivers ----------------
    task automatic wait_gnt(input bit is_ls, input string tag);
        int n = 0;
        #1;
        while (!(is_ls ? bus.ls_gnt : bus.if_gnt) && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq(tag, {31'h0, (is_ls ? bus.ls_gnt : bus.if_gnt)}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic if_txn(input logic [31:0] a, input logic [31:0] rd, input int wait_n);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        wait_gnt(1'b0, "if_gnt");
        bus.if_req = 1'b0;
        check_eq("if_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
        check_eq("if_be", {28'h0, bus.mem_be}, 32'hF);
        check_eq("if_we", {31'h0, bus.mem_we}, 32'h0);
        for (int w = 0; w <= wait_n; w++) begin
            check_eq("if_busy_req", {31'h0, bus.mem_req}, 32'h1);
            check_eq("if_busy_valid", {31'h0, bus.if_valid}, 32'h0);
            bus.mem_ready = (w == wait_n);
            bus.mem_rdata = (w == wait_n) ? rd : $urandom;
            tick();
        end
        bus.mem_ready = 1'b0;
        check_eq("if_valid", {31'h0, bus.if_valid}, 32'h1);
        check_eq("if_rdata", bus.if_rdata, rd);
        check_eq("if_err", {31'h0, bus.if_err}, 32'h0);
        check_eq("if_req_drop", {31'h0, bus.mem_req}, 32'h0);
        tick();
        check_eq("if_valid_pulse", {31'h0, bus.if_valid}, 32'h0);
    endtask

    task automatic ls_txn(input logic we, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int wait_n,
                          output logic [31:0] rdata_seen, output logic [31:0] wdata_seen);
        bus.ls_req   = 1'b1;
        bus.ls_we    = we;
        bus.ls_ctrl  = c;
        bus.ls_addr  = a;
        bus.ls_wdata = wd;
        wait_gnt(1'b1, "ls_gnt");
        bus.ls_req = 1'b0;
        wdata_seen = bus.mem_wdata;
        if (!ref_legal(we, c, a)) begin
            check_eq("ls_illegal_noreq", {31'h0, bus.mem_req}, 32'h0);
            check_eq("ls_illegal_valid", {31'h0, bus.ls_valid}, 32'h1);
            check_eq("ls_illegal_err", {31'h0, bus.ls_err}, 32'h1);
            check_eq("ls_illegal_rdata", bus.ls_rdata, 32'h0);
            rdata_seen = bus.ls_rdata;
            tick();
            check_eq("ls_illegal_pulse", {31'h0, bus.ls_valid}, 32'h0);
            check_eq("ls_illegal_noreq2", {31'h0, bus.mem_req}, 32'h0);
        end else begin
            check_eq("ls_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
            check_eq("ls_be", {28'h0, bus.mem_be}, {28'h0, ref_be(c, a)});
            check_eq("ls_we", {31'h0, bus.mem_we}, {31'h0, we});
            if (we) check_eq("ls_wdata", bus.mem_wdata, ref_wdata(c, wd));
            for (int w = 0; w <= wait_n; w++) begin
                check_eq("ls_busy_req", {31'h0, bus.mem_req}, 32'h1);
                bus.mem_ready = (w == wait_n);
                bus.mem_rdata = (w == wait_n) ? rd : $urandom;
                tick();
            end
            bus.mem_ready = 1'b0;
            check_eq("ls_valid", {31'h0, bus.ls_valid}, 32'h1);
            check_eq("ls_err", {31'h0, bus.ls_err}, 32'h0);
            check_eq("ls_rdata", bus.ls_rdata, we ? 32'h0 : ref_load(c, a, rd));
            rdata_seen = bus.ls_rdata;
            tick();
            check_eq("ls_valid_pulse", {31'h0, bus.ls_valid}, 32'h0);
        end
    endtask

    // Both requesters held high with a zero-wait bus; returns the grant order (1 = LS).
    task automatic run_both(input int n_gnt, output bit order[$]);
        int cyc = 0;
        order.delete();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0200;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_ctrl = 3'b010;
        bus.ls_addr = 32'h0000_0040;
        while (order.size() < n_gnt && cyc < 400) begin
            #1;
            if (bus.ls_gnt || bus.if_gnt) begin
                check_eq("one_gnt", {31'h0, bus.ls_gnt & bus.if_gnt}, 32'h0);
                order.push_back(bus.ls_gnt);
            end
            @(posedge clk);
            #1;
            cyc++;
            bus.mem_ready = bus.mem_req;
            bus.mem_rdata = $urandom;
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        check_eq("both_budget", order.size(), n_gnt);
        repeat (4) begin
            tick();
            bus.mem_ready = bus.mem_req;
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] r, w;
        bit          order[$];
        logic        we;
        logic [2:0]  c;
        logic [31:0] a;
        int          sz;

        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_ctrl = 3'b010;
        bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_if_gnt", {31'h0, bus.if_gnt}, 32'h0);
        check_eq("rst_ls_gnt", {31'h0, bus.ls_gnt}, 32'h0);
        check_eq("rst_valids", {30'h0, bus.if_valid, bus.ls_valid}, 32'h0);
        check_eq("rst_errs", {30'h0, bus.if_err, bus.ls_err}, 32'h0);
        check_eq("rst_if_rdata", bus.if_rdata, 32'h0);
        check_eq("rst_ls_rdata", bus.ls_rdata, 32'h0);
        check_eq("rst_mem_ctl", {26'h0, bus.mem_req, bus.mem_we, bus.mem_be}, 32'h0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        rst = 1'b0;
        tick();

        if_txn(32'h0000_0104, 32'hCAFE_0104, 0);
        ls_txn(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_FF00, 0, r, w);
        check_eq("lb_value", r, 32'hFFFF_FF80);
        ls_txn(1'b0, 3'b011, 32'h0000_0203, 32'h0, 32'h80FF_FF00, 1, r, w);
        check_eq("lbu_value", r, 32'h0000_0080);
        ls_txn(1'b1, 3'b110, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 0, r, w);
        check_eq("sh_wdata", w, 32'hABCD_ABCD);
        ls_txn(1'b1, 3'b111, 32'h0000_0101, 32'hDEAD_BEEF, 32'h0, 0, r, w);
        ls_txn(1'b1, 3'b000, 32'h0000_0100, 32'h0, 32'h0, 0, r, w);
        ls_txn(1'b0, 3'b001, 32'h0000_0106, 32'h0, 32'h8001_7FFF, 7, r, w);
        check_eq("lh_hi_value", r, 32'hFFFF_8001);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if_txn($urandom, $urandom, $urandom_range(0, 3));
            end else begin
                c  = 3'($urandom_range(0, 7));
                we = (c >= 3'd5);
                if ($urandom_range(0, 9) == 0) we = ~we;
                a  = $urandom;
                sz = ref_size(c);
                if ($urandom_range(0, 9) < 7) a = a & ~(32'(sz) - 32'd1);
                ls_txn(we, c, a, $urandom, $urandom, $urandom_range(0, 3), r, w);
            end
        end

        do_reset();
        run_both(12, order);
        for (int i = 0; i < order.size(); i++)
            check_eq($sformatf("starve_order_%0d", i), {31'h0, order[i]},
                     (i % 5 == 4) ? 32'h0 : 32'h1);

        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_ctrl = 3'b010; bus.ls_addr = 32'h80;
        wait_gnt(1'b1, "mid_rst_gnt");
        bus.ls_req = 1'b0;
        check_eq("mid_rst_busy", {31'h0, bus.mem_req}, 32'h1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_req", {31'h0, bus.mem_req}, 32'h0);
        check_eq("mid_rst_bus", {bus.mem_addr[27:0], bus.mem_be}, 32'h0);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (3) begin
            tick();
            check_eq("mid_rst_novalid", {30'h0, bus.if_valid, bus.ls_valid}, 32'h0);
            check_eq("mid_rst_idle_req", {31'h0, bus.mem_req}, 32'h0);
        end
        bus.mem_ready = 1'b0;
        run_both(5, order);
        for (int i = 0; i < order.size(); i++)
            check_eq($sformatf("post_rst_order_%0d", i), {31'h0, order[i]},
                     (i == 4) ? 32'h0 : 32'h1);

`ifdef MEM_TIMEOUT_EN
        begin
            int n = 0;
            bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_ctrl = 3'b010; bus.ls_addr = 32'h10;
            wait_gnt(1'b1, "to_gnt");
            bus.ls_req = 1'b0;
            bus.mem_ready = 1'b0;
            while (bus.mem_req && n < 40) begin
                n++;
                tick();
            end
            check_eq("to_busy_cycles", n, 8);
            check_eq("to_valid", {31'h0, bus.ls_valid}, 32'h1);
            check_eq("to_err", {31'h0, bus.ls_err}, 32'h1);
            check_eq("to_rdata", bus.ls_rdata, 32'h0);
            tick();
            check_eq("to_pulse", {31'h0, bus.ls_valid}, 32'h0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
